// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS control path: field widths, opcode and
//   funct constants, the ALU-operation class (aluop_t) and the multicycle
//   controller state encoding (mc_state_t, 4 bits).
//   Optional feature macro: MC_ADDI_EN adds the ADDIEX/ADDIWB states.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int OP_W     = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALUCTL_W = 3;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
`endif
    } mc_state_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// ---------------------------------------------------------------------------
// aludec
//   ALU decoder shared with the single-cycle core. Maps the ALU-operation
//   class and the R-type funct field to the 3-bit ALU control code.
//   Ports:
//     funct      in   FUNCT_W   funct field from the instruction
//     aluop      in   aluop_t   ADD / SUB / FUNCT class from the controller
//     alucontrol out  ALUCTL_W  ALU operation (010 add, 110 sub, 000 and,
//                               001 or, 111 slt)
// ---------------------------------------------------------------------------
module aludec
    import mips_pkg::*;
#(
    parameter int FUNCT_W  = mips_pkg::FUNCT_W,
    parameter int ALUCTL_W = mips_pkg::ALUCTL_W
) (
    input  logic [FUNCT_W-1:0]  funct,
    input  aluop_t              aluop,
    output logic [ALUCTL_W-1:0] alucontrol
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for alucontrol.
        alucontrol = 3'b010;
        case (aluop)
            ALUOP_ADD: alucontrol = 3'b010;
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010; // unknown funct falls back to add
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Multicycle MIPS control unit. A Moore FSM walks each instruction through
//   FETCH/DECODE/execute/writeback, one datapath stage per cycle, driving the
//   shared-memory multicycle datapath.
//   Optional feature macro: MC_ADDI_EN enables the addi path
//   (DECODE -> ADDIEX -> ADDIWB -> FETCH); without it addi is treated as an
//   illegal opcode and executes as a NOP.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high; returns the FSM to FETCH
//     op         in   opcode from the instruction register
//     funct      in   funct from the instruction register
//     zero       in   ALU zero flag (meaningful in BEQEX)
//     iord       out  memory address select (0 PC, 1 ALUOut)
//     memwrite   out  memory write strobe
//     irwrite    out  instruction register load
//     regdst     out  write register select (0 rt, 1 rd)
//     memtoreg   out  write data select (0 ALUOut, 1 memory data)
//     regwrite   out  register file write
//     alusrca    out  SrcA select (0 PC, 1 A)
//     alusrcb    out  SrcB select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//     pcsrc      out  PC' select (00 ALUResult, 01 ALUOut, 10 jump target)
//     pcen       out  PC load enable
//     alucontrol out  ALU operation
// ---------------------------------------------------------------------------
module mc_controller
    import mips_pkg::*;
#(
    parameter int OP_W     = mips_pkg::OP_W,
    parameter int FUNCT_W  = mips_pkg::FUNCT_W,
    parameter int ALUCTL_W = mips_pkg::ALUCTL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    output logic                iord,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic                pcen,
    output logic [ALUCTL_W-1:0] alucontrol
);

    mc_state_t state_q, state_d;
    aluop_t    aluop;
    logic      pcwrite;
    logic      branch;

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH; // illegal op runs as a NOP
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
`ifdef MC_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
`endif
            // MEMWB, MEMWR, RTYPEWB, BEQEX, JEX, ADDIWB and any unreachable
            // encoding all return to FETCH.
            default:   state_d = S_FETCH;
        endcase
    end

    // NOTE: the state register uses non-blocking assignment so every flop
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Moore output decode: everything depends on the state alone, except
    // pcen (zero) and alucontrol (funct through aludec).
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            S_DECODE:  alusrcb = 2'b11; // precompute branch target
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite = 1'b1;
`endif
            default: ;
        endcase
    end

    // Branch resolution is combinational on zero within BEQEX.
    assign pcen = pcwrite | (branch & zero);

    aludec #(
        .FUNCT_W  (FUNCT_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
//   Directed bench for the multicycle controller. Each cycle the full output
//   vector is compared with the value expected for the state the instruction
//   should be in. Honors MC_ADDI_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mc_controller;

    // Expected-state identifiers, independent of the design's encoding.
    localparam int F   = 0;
    localparam int D   = 1;
    localparam int MA  = 2;
    localparam int MR  = 3;
    localparam int MWB = 4;
    localparam int MWR = 5;
    localparam int REX = 6;
    localparam int RWB = 7;
    localparam int BEQ = 8;
    localparam int JEX = 9;
    localparam int AEX = 10;
    localparam int AWB = 11;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol}
    logic [14:0] dut_vec;
    assign dut_vec = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                      alusrca, alusrcb, pcsrc, pcen, alucontrol};

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Hand table of the funct decode used in RTYPEEX.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector for a state, given current zero and funct.
    function automatic logic [14:0] exp_vec(input int st, input logic z, input logic [5:0] f);
        logic       e_iord, e_mw, e_ir, e_rd, e_mtr, e_rw, e_asa, e_pcen;
        logic [1:0] e_asb, e_pcs;
        logic [2:0] e_alu;
        {e_iord, e_mw, e_ir, e_rd, e_mtr, e_rw, e_asa, e_pcen} = '0;
        e_asb = 2'b00;
        e_pcs = 2'b00;
        e_alu = 3'b010;
        case (st)
            F:   begin e_ir = 1'b1; e_asb = 2'b01; e_pcen = 1'b1; end
            D:   e_asb = 2'b11;
            MA:  begin e_asa = 1'b1; e_asb = 2'b10; end
            MR:  e_iord = 1'b1;
            MWB: begin e_mtr = 1'b1; e_rw = 1'b1; end
            MWR: begin e_iord = 1'b1; e_mw = 1'b1; end
            REX: begin e_asa = 1'b1; e_alu = funct_alu(f); end
            RWB: begin e_rd = 1'b1; e_rw = 1'b1; end
            BEQ: begin e_asa = 1'b1; e_alu = 3'b110; e_pcs = 2'b01; e_pcen = z; end
            JEX: begin e_pcs = 2'b10; e_pcen = 1'b1; end
            AEX: begin e_asa = 1'b1; e_asb = 2'b10; end
            AWB: e_rw = 1'b1;
            default: ;
        endcase
        return {e_iord, e_mw, e_ir, e_rd, e_mtr, e_rw, e_asa, e_asb, e_pcs, e_pcen, e_alu};
    endfunction

    // Called at a negedge with the FSM in FETCH; checks n consecutive cycles
    // against the expected state trace and returns at a negedge.
    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int n,
                       input int s0, input int s1, input int s2, input int s3, input int s4);
        int st;
        op    = o;
        funct = f;
        zero  = z;
        for (int i = 0; i < n; i++) begin
            case (i)
                0: st = s0;
                1: st = s1;
                2: st = s2;
                3: st = s3;
                default: st = s4;
            endcase
            check($sformatf("%s_c%0d", tag, i), dut_vec, exp_vec(st, zero, funct));
            @(negedge clk);
        end
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;

        // 1: reset held two cycles, FETCH outputs, then DECODE
        @(negedge clk);
        @(negedge clk);
        check("reset_fetch", dut_vec, exp_vec(F, 1'b0, 6'b0));
        reset = 1'b0;
        check("post_reset_fetch", dut_vec, 15'b001_0000_01_00_1_010);
        op = 6'b111111;
        @(negedge clk);
        check("post_reset_decode", dut_vec, 15'b000_0000_11_00_0_010);
        @(negedge clk);

        // 2: lw, 5 cycles, memtoreg/regwrite only in MEMWB
        run("lw", 6'b100011, 6'b0, 1'b0, 5, F, D, MA, MR, MWB);
        // sw, 4 cycles
        run("sw", 6'b101011, 6'b0, 1'b0, 4, F, D, MA, MWR, F);

        // 3: beq taken and not taken
        run("beq_z1", 6'b000100, 6'b0, 1'b1, 3, F, D, BEQ, F, F);
        run("beq_z0", 6'b000100, 6'b0, 1'b0, 3, F, D, BEQ, F, F);

        // 4: R-type funct decode including unknown funct
        run("slt",  6'b000000, 6'b101010, 1'b0, 4, F, D, REX, RWB, F);
        run("add",  6'b000000, 6'b100000, 1'b0, 4, F, D, REX, RWB, F);
        run("sub",  6'b000000, 6'b100010, 1'b0, 4, F, D, REX, RWB, F);
        run("and",  6'b000000, 6'b100100, 1'b0, 4, F, D, REX, RWB, F);
        run("or",   6'b000000, 6'b100101, 1'b0, 4, F, D, REX, RWB, F);
        run("nor",  6'b000000, 6'b100111, 1'b0, 4, F, D, REX, RWB, F);

        // j, 3 cycles
        run("j", 6'b000010, 6'b0, 1'b0, 3, F, D, JEX, F, F);

        // 5: addi
`ifdef MC_ADDI_EN
        run("addi", 6'b001000, 6'b0, 1'b0, 4, F, D, AEX, AWB, F);
`else
        run("addi", 6'b001000, 6'b0, 1'b0, 2, F, D, F, F, F);
`endif

        // 6: reset during MEMWR abandons the store
        run("sw_rst", 6'b101011, 6'b0, 1'b0, 4, F, D, MA, MWR, F);
        // run() left us one negedge past MEMWR; replay to land in MEMWR
        run("sw_rst2", 6'b101011, 6'b0, 1'b0, 3, F, D, MA, F, F);
        check("in_memwr", dut_vec, exp_vec(MWR, 1'b0, 6'b0));
        reset = 1'b1;
        @(negedge clk);
        check("rst_memwr_fetch", dut_vec, exp_vec(F, 1'b0, 6'b0));
        reset = 1'b0;
        // illegal op runs as a 2-cycle NOP, then a final fetch check
        run("nop", 6'b111111, 6'b0, 1'b0, 3, F, D, F, F, F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
